z_bitpack: RTL and testbench
============================

Name: z_bitpack

Overview:
- Downstream stage of the mask-expansion / response path.
- Reads signed 24-bit coefficients of an L-polynomial vector (y or z, 4 coeffs per 96-bit word) from the NTT-domain RAM.
- Encodes each coefficient as gamma1 - coeff in COEFF_BIT_LEN bits (FIPS 204 BitPack, little-endian bit order).
- Writes the packed stream as 64-bit words into the raw-data RAM for signature assembly.

Parameters:
- L, 7, number of polynomials.
- GAMMA1, 19, log2(gamma1).
- COEFF_BIT_LEN, GAMMA1+1, packed bits per coefficient.
- COEFF_WIDTH, 24, signed coefficient width in source RAM.
- COEFF_PER_WORD, 4, coefficients per source word.
- WORD_WIDTH, 64, destination word width.
- NTT_ADDR_WIDTH, 12, source address width.
- DATA_ADDR_WIDTH, 12, destination address width.
- SRC_BASE, 0, first source word address.
- DST_BASE, 0, first destination word address.
- BETA, 120, norm margin (used only with Z_NORM_CHECK_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins packing; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last destination write.
- addr_src  out  NTT_ADDR_WIDTH  source RAM read address.
- dout_src  in  COEFF_WIDTH*COEFF_PER_WORD  source RAM read data; registered RAM, 1-cycle latency.
- we_dst  out  1  destination write enable.
- addr_dst  out  DATA_ADDR_WIDTH  destination address.
- din_dst  out  WORD_WIDTH  destination write data.
- reject  out  1  sticky norm-violation flag (see Optional Feature).

Behaviour:
- Reset: all outputs 0, FSM in IDLE, bit buffer cleared, fill count 0, counters 0.
- Sizes:
  - Source words = L*256/COEFF_PER_WORD (448 at default).
  - Destination words = L*256*COEFF_BIT_LEN/WORD_WIDTH (560 at default).
  - Integral for COEFF_BIT_LEN 18 and 20.
- FSM states:
  - IDLE: on start, load src_cnt=0, dst_cnt=0, fill=0, clear reject; go to READ.
  - READ: drive addr_src = SRC_BASE+src_cnt; go to WAIT.
  - WAIT: one cycle for RAM latency; go to PACK.
  - PACK: for each of the 4 coeffs (coeff j = bits [24j+23:24j]), sign-extend to 25 bits, compute gamma1 - coeff, keep the low COEFF_BIT_LEN bits. Concatenate coeff 0 at the lowest bits and OR into the 144-bit buffer at offset fill. Add 80 to fill, increment src_cnt, go to EMIT.
  - EMIT: while fill >= 64, write one word per cycle: we_dst=1, addr_dst=DST_BASE+dst_cnt, din_dst=buffer[63:0]; shift buffer right 64, subtract 64 from fill, increment dst_cnt. When fill < 64: go to READ if src_cnt < total, else DONE.
  - DONE: done=1 for one cycle, busy=0; go to IDLE.
- Buffer invariant: fill < 64 entering PACK, so the maximum is 143 bits.
- we_dst is high only in EMIT write cycles. addr_dst and din_dst hold their last values otherwise.
- Packing is exact for inputs in (-gamma1, gamma1]. Out-of-range inputs are truncated silently.
- Destination address wraps modulo 2^DATA_ADDR_WIDTH; no overflow detection.
- rst_n asserted mid-operation aborts immediately. Partially written destination contents are undefined, and no done pulse is issued.
- A start coinciding with DONE is ignored.

Optional Feature:
- Macro Z_NORM_CHECK_EN.
- Defined: in PACK, reject is set (sticky until the next accepted start) if any coeff satisfies |coeff| >= gamma1 - BETA. Packing still completes normally.
- Undefined: reject is tied to 0 and no comparator logic is generated.

Decomposition:
- Shared package (mldsa_pkg): GAMMA1/COEFF_BIT_LEN per parameter set, COEFF_WIDTH, COEFF_PER_WORD, WORD_WIDTH, the FSM state enum, and N=256.
- One natural sub-module, coeff_encode: combinational gamma1 - coeff plus the optional norm comparator, instantiated 4x.

Test Plan:
- All-zero vector, L=7: 560 writes; every word = 64'h0800008000080000 or its rotated continuation; done 1 cycle after the 560th write; busy low afterwards.
- coeff0 = 524288 (gamma1), others 0 → first word bits[19:0] = 0. coeff0 = -524287 → bits[19:0] = 20'hFFFFF.
- Ramp coeff i = i-128 per polynomial → destination matches a software BitPack golden model byte-for-byte; addr_dst runs DST_BASE..DST_BASE+559.
- Z_NORM_CHECK_EN, BETA=120: coeff 524167 → reject=0. Coeff 524168 → reject=1 and held to the end; next start clears it.
- rst_n low during EMIT of word 100 → all outputs 0 immediately; no done. A new start then packs correctly from word 0.
- start pulse while busy → ignored; exactly 560 writes and one done pulse.

Source files
------------

// File: rtl/mldsa_pkg.sv
// Shared ML-DSA constants for the z/y packing path: coefficient geometry,
// gamma1 selection and the packer FSM state codes.
package mldsa_pkg;

   localparam int N              = 256;
   localparam int GAMMA1         = 19;
   localparam int COEFF_BIT_LEN  = GAMMA1 + 1;
   localparam int COEFF_WIDTH    = 24;
   localparam int COEFF_PER_WORD = 4;
   localparam int WORD_WIDTH     = 64;
   localparam int BETA           = 120;

   // One source word contributes PACK_BITS; the buffer must hold a partial word plus that.
   localparam int PACK_BITS = COEFF_PER_WORD * COEFF_BIT_LEN;
   localparam int BUF_BITS  = WORD_WIDTH + PACK_BITS;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_READ = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_PACK = 3'd3;
   localparam logic [2:0] S_EMIT = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/coeff_encode.sv
// Encodes one signed coefficient as gamma1 - coeff in COEFF_BIT_LEN bits.
// With Z_NORM_CHECK_EN defined it also flags |coeff| >= gamma1 - BETA.
module coeff_encode
   import mldsa_pkg::*;
(
   input  logic [COEFF_WIDTH-1:0]   coeff,
   output logic [COEFF_BIT_LEN-1:0] enc
`ifdef Z_NORM_CHECK_EN
   ,
   output logic                     viol
`endif
);

   // Only the low COEFF_BIT_LEN bits of the difference survive, so the
   // subtraction is done at that width; upper coefficient bits drop out.
   assign enc = COEFF_BIT_LEN'(1 << GAMMA1) - coeff[COEFF_BIT_LEN-1:0];

`ifdef Z_NORM_CHECK_EN
   logic [COEFF_WIDTH-1:0] mag;

   assign mag  = coeff[COEFF_WIDTH-1] ? (~coeff + 1'b1) : coeff;
   assign viol = (mag >= COEFF_WIDTH'((1 << GAMMA1) - BETA));
`else
   logic unused_hi;

   assign unused_hi = ^coeff[COEFF_WIDTH-1:COEFF_BIT_LEN];
`endif

endmodule

// File: rtl/z_bitpack.sv
// BitPack of an L-polynomial y/z vector from NTT RAM into 64-bit raw-data words.
// Optional norm check enabled by defining Z_NORM_CHECK_EN.
module z_bitpack
   import mldsa_pkg::*;
#(
   parameter int L               = 7,
   parameter int NTT_ADDR_WIDTH  = 12,
   parameter int DATA_ADDR_WIDTH = 12,
   parameter int SRC_BASE        = 0,
   parameter int DST_BASE        = 0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   output logic                                  busy,
   output logic                                  done,
   output logic [NTT_ADDR_WIDTH-1:0]             addr_src,
   input  logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] dout_src,
   output logic                                  we_dst,
   output logic [DATA_ADDR_WIDTH-1:0]            addr_dst,
   output logic [WORD_WIDTH-1:0]                 din_dst,
   output logic                                  reject,
   output logic [2:0]                            dbg_state
);

   localparam int SRC_WORDS = L * N / COEFF_PER_WORD;
   localparam int CNT_W     = $clog2(SRC_WORDS + 1);
   localparam int FILL_W    = $clog2(BUF_BITS + 1);

   logic [2:0]                 state;
   logic [CNT_W-1:0]           src_cnt;
   logic [DATA_ADDR_WIDTH-1:0] dst_cnt;
   logic [FILL_W-1:0]          fill;
   logic [BUF_BITS-1:0]        bit_buf;
   logic [DATA_ADDR_WIDTH-1:0] addr_hold;
   logic [WORD_WIDTH-1:0]      din_hold;
   logic [PACK_BITS-1:0]       packed_word;
   logic [DATA_ADDR_WIDTH-1:0] wr_addr;
   logic                       emit_wr;

`ifdef Z_NORM_CHECK_EN
   logic [COEFF_PER_WORD-1:0]  viol;
`endif

   for (genvar j = 0; j < COEFF_PER_WORD; j++) begin : g_enc
      coeff_encode u_enc (
         .coeff (dout_src[j*COEFF_WIDTH +: COEFF_WIDTH]),
         .enc   (packed_word[j*COEFF_BIT_LEN +: COEFF_BIT_LEN])
`ifdef Z_NORM_CHECK_EN
         ,
         .viol  (viol[j])
`endif
      );
   end

   assign emit_wr   = (state == S_EMIT) && (fill >= FILL_W'(WORD_WIDTH));
   assign wr_addr   = DATA_ADDR_WIDTH'(DST_BASE) + dst_cnt;
   assign we_dst    = emit_wr;
   assign addr_dst  = emit_wr ? wr_addr : addr_hold;
   assign din_dst   = emit_wr ? bit_buf[WORD_WIDTH-1:0] : din_hold;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign done      = (state == S_DONE);
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         src_cnt   <= '0;
         dst_cnt   <= '0;
         fill      <= '0;
         bit_buf   <= '0;
         addr_src  <= '0;
         addr_hold <= '0;
         din_hold  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  src_cnt <= '0;
                  dst_cnt <= '0;
                  fill    <= '0;
                  bit_buf <= '0;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               addr_src <= NTT_ADDR_WIDTH'(SRC_BASE) + NTT_ADDR_WIDTH'(src_cnt);
               state    <= S_WAIT;
            end
            S_WAIT: state <= S_PACK;
            S_PACK: begin
               bit_buf <= bit_buf | (BUF_BITS'(packed_word) << fill);
               fill    <= fill + FILL_W'(PACK_BITS);
               src_cnt <= src_cnt + 1'b1;
               state   <= S_EMIT;
            end
            S_EMIT: begin
               if (emit_wr) begin
                  bit_buf   <= bit_buf >> WORD_WIDTH;
                  fill      <= fill - FILL_W'(WORD_WIDTH);
                  dst_cnt   <= dst_cnt + 1'b1;
                  addr_hold <= wr_addr;
                  din_hold  <= bit_buf[WORD_WIDTH-1:0];
               end
               // Leave on the last write so done follows it directly.
               if (fill < FILL_W'(2 * WORD_WIDTH))
                  state <= (src_cnt < CNT_W'(SRC_WORDS)) ? S_READ : S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef Z_NORM_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         reject <= 1'b0;
      else if (state == S_IDLE && start)
         reject <= 1'b0;
      else if (state == S_PACK && (|viol))
         reject <= 1'b1;
   end
`else
   assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_z_bitpack.sv
// Directed bench for z_bitpack: packs whole L=7 vectors from a RAM model and
// compares every destination word against a bit-serial BitPack reference.
module tb_z_bitpack;
   import mldsa_pkg::*;

   localparam int NCOEF  = 7 * 256;
   localparam int NSRC   = NCOEF / 4;
   localparam int NDST   = NCOEF * COEFF_BIT_LEN / 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, we_dst, reject;
   logic [11:0] addr_src, addr_dst;
   logic [95:0] dout_src;
   logic [63:0] din_dst;
   logic [2:0]  dbg_state;

   logic [95:0] mem [0:4095];
   int          coef [0:NCOEF-1];
   logic [63:0] exp_q[$];
   logic [11:0] wa_q[$];
   logic [63:0] wd_q[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          last_wr_cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   z_bitpack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .addr_src  (addr_src),
      .dout_src  (dout_src),
      .we_dst    (we_dst),
      .addr_dst  (addr_dst),
      .din_dst   (din_dst),
      .reject    (reject),
      .dbg_state (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // source RAM model, registered read
   always @(posedge clk) dout_src <= mem[addr_src];

   // write / done monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (we_dst) begin
            wa_q.push_back(addr_dst);
            wd_q.push_back(din_dst);
            last_wr_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // stimulus loaders
   task automatic load_mem();
      for (int w = 0; w < 4096; w++) mem[w] = '0;
      for (int k = 0; k < NCOEF; k++) mem[k/4][(k%4)*24 +: 24] = 24'(coef[k]);
   endtask

   task automatic load_fill(input int v);
      for (int k = 0; k < NCOEF; k++) coef[k] = v;
   endtask

   task automatic load_ramp();
      for (int k = 0; k < NCOEF; k++) coef[k] = (k % 256) - 128;
   endtask

   // reference BitPack: bit p of the stream is bit p%20 of encoding p/20
   task automatic build_expected();
      logic [19:0] e;
      logic [63:0] word;
      int          pos;
      exp_q.delete();
      for (int w = 0; w < NDST; w++) begin
         for (int b = 0; b < 64; b++) begin
            pos     = 64 * w + b;
            e       = 20'((1 << 19) - coef[pos / 20]);
            word[b] = e[pos % 20];
         end
         exp_q.push_back(word);
      end
   endtask

   // driver
   task automatic run_pack(output bit timed_out);
      int d0;
      d0 = done_cnt;
      wa_q.delete();
      wd_q.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      timed_out = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (done_cnt != d0) begin
            timed_out = 1'b0;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({busy, done, we_dst, reject} !== 4'b0 || addr_src !== 12'd0 ||
          addr_dst !== 12'd0 || din_dst !== 64'd0 || dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL reset_outputs got busy=%b done=%b we=%b rej=%b as=%h ad=%h dd=%h st=%0d want all 0",
                  busy, done, we_dst, reject, addr_src, addr_dst, din_dst, dbg_state);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero();
      bit to;
      int d0;
      load_fill(0);
      load_mem();
      build_expected();
      d0 = done_cnt;
      run_pack(to);
      n_checks++;
      if (to) begin n_fail++; $display("FAIL zero_timeout got no done want done"); end
      n_checks++;
      if (wd_q.size() != NDST) begin
         n_fail++; $display("FAIL zero_count got %0d want %0d", wd_q.size(), NDST);
      end
      n_checks++;
      if (wd_q.size() > 1 && (wd_q[0] !== 64'h0800008000080000 || wd_q[1] !== 64'h0080000800008000)) begin
         n_fail++; $display("FAIL zero_first_words got %h %h want 0800008000080000 0080000800008000", wd_q[0], wd_q[1]);
      end
      for (int i = 0; i < wd_q.size() && i < NDST; i++) begin
         n_checks++;
         if (wd_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL zero_word[%0d] got %h want %h", i, wd_q[i], exp_q[i]);
         end
      end
      n_checks++;
      if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL zero_done_count got %0d want %0d", done_cnt - d0, 1); end
      n_checks++;
      if (done_cyc != last_wr_cyc + 1) begin
         n_fail++; $display("FAIL zero_done_latency got %0d want 1", done_cyc - last_wr_cyc);
      end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after got %b want 0", busy); end
   endtask

   task automatic test_boundary();
      bit to;
      load_fill(0);
      coef[0] = 524288;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || wd_q.size() == 0 || wd_q[0] !== 64'h0800008000000000) begin
         n_fail++; $display("FAIL bound_gamma1 got %h want 0800008000000000", (wd_q.size() > 0) ? wd_q[0] : 64'hx);
      end
      coef[0] = -524287;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || wd_q.size() == 0 || wd_q[0][19:0] !== 20'hFFFFF || wd_q[0] !== 64'h08000080000FFFFF) begin
         n_fail++; $display("FAIL bound_neg got %h want 08000080000FFFFF", (wd_q.size() > 0) ? wd_q[0] : 64'hx);
      end
   endtask

   task automatic test_ramp();
      bit to;
      load_ramp();
      load_mem();
      build_expected();
      run_pack(to);
      n_checks++;
      if (to || wd_q.size() != NDST) begin
         n_fail++; $display("FAIL ramp_count got %0d want %0d", wd_q.size(), NDST);
      end
      for (int i = 0; i < wd_q.size() && i < NDST; i++) begin
         n_checks++;
         if (wd_q[i] !== exp_q[i] || wa_q[i] !== 12'(i)) begin
            n_fail++; $display("FAIL ramp_word[%0d] got %h@%0d want %h@%0d", i, wd_q[i], wa_q[i], exp_q[i], i);
         end
      end
   endtask

   task automatic test_norm();
      bit to;
`ifdef Z_NORM_CHECK_EN
      load_fill(0);
      coef[900] = 524167;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || reject !== 1'b0) begin n_fail++; $display("FAIL norm_below got %b want 0", reject); end
      coef[900] = 524168;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || reject !== 1'b1) begin n_fail++; $display("FAIL norm_at_limit got %b want 1", reject); end
      load_fill(0);
      load_mem();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n_checks++;
      if (reject !== 1'b0) begin n_fail++; $display("FAIL norm_clear_on_start got %b want 0", reject); end
      repeat (2500) @(negedge clk);
      coef[5] = -524168;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || reject !== 1'b1) begin n_fail++; $display("FAIL norm_negative got %b want 1", reject); end
`else
      load_fill(0);
      coef[900] = 524168;
      load_mem();
      run_pack(to);
      n_checks++;
      if (to || reject !== 1'b0) begin n_fail++; $display("FAIL norm_disabled got %b want 0", reject); end
`endif
   endtask

   task automatic test_abort();
      bit to;
      bit hit;
      int d0;
      load_ramp();
      load_mem();
      build_expected();
      d0  = done_cnt;
      hit = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk);
         #1;
         if (we_dst && addr_dst == 12'd100) begin
            hit = 1'b1;
            break;
         end
      end
      n_checks++;
      if (!hit) begin n_fail++; $display("FAIL abort_reach_word100 got none want write of word 100"); end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, we_dst, reject} !== 4'b0 || addr_src !== 12'd0 ||
          addr_dst !== 12'd0 || din_dst !== 64'd0) begin
         n_fail++; $display("FAIL abort_outputs got busy=%b done=%b we=%b as=%h ad=%h dd=%h want all 0",
                            busy, done, we_dst, addr_src, addr_dst, din_dst);
      end
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++;
      if (done_cnt != d0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", done_cnt - d0); end
      run_pack(to);
      n_checks++;
      if (to || wd_q.size() != NDST) begin
         n_fail++; $display("FAIL abort_rerun_count got %0d want %0d", wd_q.size(), NDST);
      end
      for (int i = 0; i < wd_q.size() && i < NDST; i++) begin
         n_checks++;
         if (wd_q[i] !== exp_q[i] || wa_q[i] !== 12'(i)) begin
            n_fail++; $display("FAIL abort_rerun_word[%0d] got %h@%0d want %h@%0d", i, wd_q[i], wa_q[i], exp_q[i], i);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit hit;
      int d0;
      load_fill(0);
      load_mem();
      build_expected();
      d0  = done_cnt;
      hit = 1'b0;
      wa_q.delete();
      wd_q.delete();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_high got %b want 1", busy); end
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         start = (i == 20 || i == 700 || i == 1500);
         if (done) begin
            start = 1'b1;
            hit   = 1'b1;
            break;
         end
      end
      @(negedge clk) start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (!hit || busy !== 1'b0 || dbg_state !== S_IDLE) begin
         n_fail++; $display("FAIL b2b_idle_after got busy=%b st=%0d want busy=0 st=0", busy, dbg_state);
      end
      n_checks++;
      if (wd_q.size() != NDST) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", wd_q.size(), NDST); end
      n_checks++;
      if (done_cnt != d0 + 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", done_cnt - d0); end
      for (int i = 0; i < wd_q.size() && i < NDST; i++) begin
         n_checks++;
         if (wd_q[i] !== exp_q[i]) begin
            n_fail++; $display("FAIL b2b_word[%0d] got %h want %h", i, wd_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_boundary();
      test_ramp();
      test_norm();
      test_abort();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
